// File: rtl/uart_pkg.sv
// uart_pkg: shared UART baud-generator constants and a width helper.
package uart_pkg;
  localparam int UART_CNT_W = 16;
  localparam int UART_FRAC_W = 4;
  localparam int UART_OVERSAMPLE = 16;
  localparam int UART_DEFAULT_DIV = 164;
  function automatic int clog2(input int v);
    int r;
    r = 1;
    for (int i = 1; i < 32; i++) if ((1 << i) < v) r = i + 1;
    return r;
  endfunction
endpackage

// File: rtl/baud_div_core.sv
// baud_div_core: fractional-N period generator producing the raw one-cycle TICK.
module baud_div_core #(
  parameter int CNT_W = 16,
  parameter int FRAC_W = 4
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              i_en,
  input  logic              i_clr,
  input  logic [CNT_W-1:0]  i_div_int,
  input  logic [FRAC_W-1:0] i_div_frac,
  output logic              o_wrap,
  output logic              o_tick,
  output logic [CNT_W-1:0]  o_cnt
);
  logic [CNT_W-1:0] r_cnt;
  logic [FRAC_W-1:0] r_acc;
  logic r_tick;
  logic [CNT_W-1:0] w_d;
  logic [FRAC_W:0] w_sum;
  logic [CNT_W:0] w_last;
  // The accumulator carry lengthens this period by one cycle.
  assign w_d = (i_div_int == '0) ? CNT_W'(1) : i_div_int;
  assign w_sum = {1'b0, r_acc} + {1'b0, i_div_frac};
  assign w_last = {1'b0, w_d} - (CNT_W+1)'(1) + (CNT_W+1)'(w_sum[FRAC_W]);
  assign o_wrap = i_en & ~i_clr & ({1'b0, r_cnt} == w_last);
  assign o_tick = r_tick;
  assign o_cnt = r_cnt;
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_cnt <= '0;
      r_acc <= '0;
      r_tick <= 1'b0;
    end else if (i_clr) begin
      r_cnt <= '0;
      r_acc <= '0;
      r_tick <= 1'b0;
    end else begin
      r_tick <= o_wrap;
      if (i_en) r_cnt <= o_wrap ? '0 : r_cnt + CNT_W'(1);
      if (o_wrap) r_acc <= w_sum[FRAC_W-1:0];
    end
  end
endmodule

// File: rtl/baud_tick_gen.sv
// baud_tick_gen: programmable baud tick generator with shadowed divisor reload,
// receiver resync, and bit / half-bit ticks derived from the oversample tick.
module baud_tick_gen
  import uart_pkg::*;
#(
  parameter int CNT_W = UART_CNT_W,
  parameter int FRAC_W = UART_FRAC_W,
  parameter int OVERSAMPLE = UART_OVERSAMPLE,
  parameter int DEFAULT_DIV = UART_DEFAULT_DIV
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              EN,
  input  logic [CNT_W-1:0]  DIV_INT,
  input  logic [FRAC_W-1:0] DIV_FRAC,
  input  logic              DIV_LOAD,
  input  logic              RESYNC,
  output logic              TICK,
  output logic              BIT_TICK,
  output logic              HALF_TICK,
  output logic [CNT_W-1:0]  Q
);
  localparam int SUB_W = clog2(OVERSAMPLE);
  localparam logic [SUB_W-1:0] SUB_LAST = SUB_W'(OVERSAMPLE - 1);
  localparam logic [SUB_W-1:0] SUB_MID = SUB_W'(OVERSAMPLE / 2 - 1);
  logic [CNT_W-1:0] r_sh_int, r_act_int;
  logic [FRAC_W-1:0] r_sh_frac, r_act_frac;
  logic [SUB_W-1:0] r_sub;
  logic r_bit, r_half;
  logic w_wrap;
  baud_div_core #(.CNT_W(CNT_W), .FRAC_W(FRAC_W)) u_core (
    .CLK(CLK),
    .RESET(RESET),
    .i_en(EN),
    .i_clr(RESYNC),
    .i_div_int(r_act_int),
    .i_div_frac(r_act_frac),
    .o_wrap(w_wrap),
    .o_tick(TICK),
    .o_cnt(Q)
  );
  assign BIT_TICK = r_bit;
  assign HALF_TICK = r_half;
  // Active divisor only changes on a period boundary or a resync, so no period is cut short.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_sh_int <= CNT_W'(DEFAULT_DIV);
      r_sh_frac <= '0;
      r_act_int <= CNT_W'(DEFAULT_DIV);
      r_act_frac <= '0;
      r_sub <= '0;
      r_bit <= 1'b0;
      r_half <= 1'b0;
    end else begin
      if (DIV_LOAD) begin
        r_sh_int <= DIV_INT;
        r_sh_frac <= DIV_FRAC;
      end
      if (RESYNC) begin
        r_act_int <= DIV_LOAD ? DIV_INT : r_sh_int;
        r_act_frac <= DIV_LOAD ? DIV_FRAC : r_sh_frac;
      end else if (w_wrap) begin
        r_act_int <= r_sh_int;
        r_act_frac <= r_sh_frac;
      end
      if (RESYNC) r_sub <= '0;
      else if (w_wrap) r_sub <= (r_sub == SUB_LAST) ? '0 : r_sub + SUB_W'(1);
      r_bit <= w_wrap & (r_sub == SUB_LAST);
      r_half <= w_wrap & (r_sub == SUB_MID);
    end
  end
endmodule

// File: tb/tb_baud_tick_gen.sv
// tb_baud_tick_gen: randomized scoreboard bench; the model places ticks by closed-form
// cumulative period sums per divisor segment rather than by emulating counters.
module tb_baud_tick_gen;
  logic CLK = 1'b0;
  logic RESET = 1'b1;
  logic EN = 1'b0;
  logic [15:0] DIV_INT = '0;
  logic [3:0] DIV_FRAC = '0;
  logic DIV_LOAD = 1'b0;
  logic RESYNC = 1'b0;
  logic TICK, BIT_TICK, HALF_TICK;
  logic [15:0] Q;

  typedef struct packed {
    logic t;
    logic b;
    logic h;
    logic [15:0] q;
  } exp_t;

  exp_t sb[$];
  int tests = 0;
  int fails = 0;
  int cyc = 0;

  int sh_i, sh_f, act_i, act_f;
  longint a0, k, e, tsub;

  baud_tick_gen dut (
    .CLK(CLK), .RESET(RESET), .EN(EN), .DIV_INT(DIV_INT), .DIV_FRAC(DIV_FRAC),
    .DIV_LOAD(DIV_LOAD), .RESYNC(RESYNC), .TICK(TICK), .BIT_TICK(BIT_TICK),
    .HALF_TICK(HALF_TICK), .Q(Q)
  );

  always #5 CLK = ~CLK;

  // Cycles spanned by the first n ticks of the current divisor segment.
  function automatic longint span(input longint n);
    longint dd;
    dd = (act_i == 0) ? 1 : act_i;
    return n * dd + (a0 + n * act_f) / 16;
  endfunction

  task automatic step(input bit rst, input bit en, input bit ld, input bit rs, input int di, input int df);
    exp_t x;
    x = '0;
    RESET = rst; EN = en; DIV_LOAD = ld; RESYNC = rs;
    DIV_INT = 16'(di); DIV_FRAC = 4'(df);
    if (rst) begin
      sh_i = 164; sh_f = 0; act_i = 164; act_f = 0;
      a0 = 0; k = 0; e = 0; tsub = 0;
    end else if (rs) begin
      if (ld) begin sh_i = di; sh_f = df; end
      act_i = sh_i; act_f = sh_f;
      a0 = 0; k = 0; e = 0; tsub = 0;
    end else begin
      if (en) begin
        e++;
        if (e == span(k + 1)) begin
          x.t = 1'b1;
          k++;
          tsub++;
          x.b = (tsub % 16) == 0;
          x.h = (tsub % 16) == 8;
          if (sh_i != act_i || sh_f != act_f) begin
            a0 = (a0 + k * act_f) % 16;
            act_i = sh_i; act_f = sh_f;
            k = 0; e = 0;
          end
        end
      end
      if (ld) begin sh_i = di; sh_f = df; end
    end
    x.q = 16'(e - span(k));
    sb.push_back(x);
  endtask

  task automatic run(input int n, input bit en);
    for (int i = 0; i < n; i++) begin
      @(negedge CLK);
      step(0, en, 0, 0, 0, 0);
    end
  endtask

  task automatic one(input bit rst, input bit en, input bit ld, input bit rs, input int di, input int df);
    @(negedge CLK);
    step(rst, en, ld, rs, di, df);
  endtask

  initial begin
    exp_t got, x;
    forever begin
      @(posedge CLK);
      #1;
      cyc++;
      tests++;
      if (sb.size() == 0) begin
        fails++;
        $display("FAIL no_expect cycle %0d: output present with empty scoreboard", cyc);
      end else begin
        x = sb.pop_front();
        got = {TICK, BIT_TICK, HALF_TICK, Q};
        if (got !== x)
          begin
            fails++;
            $display("FAIL outputs cycle %0d: got tick=%b bit=%b half=%b q=%0d, want tick=%b bit=%b half=%b q=%0d",
                     cyc, got.t, got.b, got.h, got.q, x.t, x.b, x.h, x.q);
          end
      end
    end
  end

  initial begin
    step(1, 0, 0, 0, 0, 0);
    one(1, 0, 0, 0, 0, 0);
    one(1, 0, 0, 0, 0, 0);
    run(2700, 1);
    one(0, 1, 1, 1, 10, 4);
    run(200, 1);
    run(5, 1);
    one(0, 1, 1, 0, 20, 0);
    run(400, 1);
    one(0, 1, 1, 1, 164, 0);
    run(100, 1);
    run(50, 0);
    run(200, 1);
    one(0, 1, 0, 1, 0, 0);
    run(300, 1);
    one(0, 1, 1, 1, 0, 0);
    run(40, 1);
    one(0, 1, 1, 0, 1, 0);
    run(40, 1);
    one(1, 1, 0, 0, 0, 0);
    run(400, 1);
    for (int i = 0; i < 25000; i++) begin
      bit en, ld, rs, rst;
      int di;
      rst = $urandom_range(0, 2999) == 0;
      en = $urandom_range(0, 14) != 0;
      ld = $urandom_range(0, 39) == 0;
      rs = $urandom_range(0, 199) == 0;
      di = ($urandom_range(0, 49) == 0) ? 164 : int'($urandom_range(0, 15));
      one(rst, en, ld, rs, di, int'($urandom_range(0, 15)));
    end
    @(posedge CLK);
    #2;
    if (sb.size() != 0) begin
      tests++;
      fails++;
      $display("FAIL drain: %0d expectations left, want 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
